// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: response codes and FSM state types shared by the AXI4-Lite memory slave.
package axi4lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
endpackage

// File: rtl/axi4lite_mem_array.sv
// axi4lite_mem_array: byte-enabled storage, one write port and one registered read port (read-before-write).
module axi4lite_mem_array #(
  parameter int DATA_BITS   = 64,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [DATA_BITS-1:0]           wdata,
  input  logic [DATA_BITS/8-1:0]         wstrb,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [DATA_BITS-1:0]           rdata
);
  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we)
      for (int i = 0; i < DATA_BITS/8; i++)
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule

// File: rtl/axi4lite_mem_slave.sv
// axi4lite_mem_slave: single-beat AXI4-Lite memory slave with independent read and write channels.
module axi4lite_mem_slave
  import axi4lite_pkg::*;
#(
  parameter int                   ADDR_BITS   = 32,
  parameter int                   DATA_BITS   = 64,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                   DEPTH_WORDS = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axi4lite_aw_valid,
  output logic                   s_axi4lite_aw_ready,
  input  logic [ADDR_BITS-1:0]   s_axi4lite_aw_addr,
  input  logic [2:0]             s_axi4lite_aw_prot,
  input  logic                   s_axi4lite_w_valid,
  output logic                   s_axi4lite_w_ready,
  input  logic [DATA_BITS-1:0]   s_axi4lite_w_data,
  input  logic [DATA_BITS/8-1:0] s_axi4lite_w_strb,
  output logic                   s_axi4lite_b_valid,
  input  logic                   s_axi4lite_b_ready,
  output logic [1:0]             s_axi4lite_b_resp,
  input  logic                   s_axi4lite_ar_valid,
  output logic                   s_axi4lite_ar_ready,
  input  logic [ADDR_BITS-1:0]   s_axi4lite_ar_addr,
  input  logic [2:0]             s_axi4lite_ar_prot,
  output logic                   s_axi4lite_r_valid,
  input  logic                   s_axi4lite_r_ready,
  output logic [DATA_BITS-1:0]   s_axi4lite_r_data,
  output logic [1:0]             s_axi4lite_r_resp
);
  localparam int OFF_BITS = $clog2(DATA_BITS/8);
  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  function automatic logic hit(input logic [ADDR_BITS-1:0] a);
    return a >= BASE_ADDR && ((a - BASE_ADDR) >> OFF_BITS) < ADDR_BITS'(DEPTH_WORDS);
  endfunction
  function automatic logic [IDX_BITS-1:0] idx(input logic [ADDR_BITS-1:0] a);
    return IDX_BITS'((a - BASE_ADDR) >> OFF_BITS);
  endfunction
  wstate_t wstate, w_next;
  rstate_t rstate, r_next;
  logic aw_full, w_full, r_zero, aw_hs, w_hs, ar_hs, commit, unused;
  logic [ADDR_BITS-1:0] aw_addr_q;
  logic [DATA_BITS-1:0] w_data_q, mem_rdata;
  logic [DATA_BITS/8-1:0] w_strb_q;
  assign unused = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot};
  assign s_axi4lite_aw_ready = ~rst & ~aw_full & (wstate == W_IDLE);
  assign s_axi4lite_w_ready  = ~rst & ~w_full & (wstate == W_IDLE);
  assign s_axi4lite_ar_ready = ~rst & (rstate == R_IDLE);
  assign aw_hs  = s_axi4lite_aw_valid & s_axi4lite_aw_ready;
  assign w_hs   = s_axi4lite_w_valid & s_axi4lite_w_ready;
  assign ar_hs  = s_axi4lite_ar_valid & s_axi4lite_ar_ready;
  assign commit = ~rst & aw_full & w_full & (wstate == W_IDLE);
  assign s_axi4lite_b_valid = wstate == W_RESP;
  assign s_axi4lite_r_valid = rstate == R_RESP;
  // out-of-range reads and the post-reset state present zero instead of stale array output
  assign s_axi4lite_r_data = r_zero ? '0 : mem_rdata;
  always_comb begin
    w_next = (wstate == W_IDLE) ? (commit ? W_RESP : W_IDLE) : (s_axi4lite_b_ready ? W_IDLE : W_RESP);
    r_next = (rstate == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (s_axi4lite_r_ready ? R_IDLE : R_RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= w_next;
      rstate <= r_next;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full           <= 1'b0;
      w_full            <= 1'b0;
      r_zero            <= 1'b1;
      s_axi4lite_b_resp <= RESP_OKAY;
      s_axi4lite_r_resp <= RESP_OKAY;
    end else begin
      aw_full <= ~commit & (aw_full | aw_hs);
      w_full  <= ~commit & (w_full | w_hs);
      if (aw_hs) aw_addr_q <= s_axi4lite_aw_addr;
      if (w_hs) begin
        w_data_q <= s_axi4lite_w_data;
        w_strb_q <= s_axi4lite_w_strb;
      end
      if (commit) s_axi4lite_b_resp <= hit(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        s_axi4lite_r_resp <= hit(s_axi4lite_ar_addr) ? RESP_OKAY : RESP_SLVERR;
        r_zero            <= ~hit(s_axi4lite_ar_addr);
      end
    end
  end
  axi4lite_mem_array #(.DATA_BITS(DATA_BITS), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .we   (commit & hit(aw_addr_q)),
    .waddr(idx(aw_addr_q)),
    .wdata(w_data_q),
    .wstrb(w_strb_q),
    .re   (ar_hs),
    .raddr(idx(s_axi4lite_ar_addr)),
    .rdata(mem_rdata)
  );
endmodule
